// File: rtl/arb16_rr4_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter with
// lockable grants.
package arb16_rr4_pkg;

  localparam int ARB_NREQ  = 4;
  localparam int ARB_WIDTH = 16;

  // Requester index; four requesters, so two bits.
  typedef logic [1:0] req_idx_t;

  // Grant ownership state: free arbitration or held by one requester.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Contents of the single output register.
  typedef struct packed {
    logic [ARB_WIDTH-1:0] data;
    req_idx_t             src;
  } out_beat_t;

endpackage

// File: rtl/arb16_rr4_pick.sv
// rr_pick4: combinational round-robin picker over four requests. The search
// starts at ptr+1 and wraps, so the most recent winner is tried last.
module rr_pick4
  import arb16_rr4_pkg::*;
(
  input  logic [3:0] req,
  input  req_idx_t   ptr,
  output logic [3:0] gnt,
  output req_idx_t   idx,
  output logic       any
);

  // Walk the four candidates in priority order; the first live request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      req_idx_t cand;
      cand = ptr + req_idx_t'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb16_rr4.sv
// arb16_rr4: four requesters share one registered output port. Round-robin
// arbitration, with a requester able to hold the grant across beats via
// req_lock. One output register gives 1-cycle latency and full throughput.
module arb16_rr4
  import arb16_rr4_pkg::*;
#(
  parameter int NREQ  = ARB_NREQ,
  parameter int WIDTH = ARB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_lock,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [1:0]            out_src,
  input  logic                  out_ready,
  output logic                  locked
);

  arb_state_t               state;
  req_idx_t                 owner;
  req_idx_t                 ptr;
  out_beat_t                beat;
  logic                     vld;

  logic [NREQ-1:0]          lock_mask;
  logic [NREQ-1:0]          eff_req;
  logic [NREQ-1:0]          gnt;
  req_idx_t                 win;
  logic                     win_any;
  logic                     can_accept;
  logic                     in_xfer;
  logic                     out_xfer;
  logic [NREQ-1:0][WIDTH-1:0] words;

  assign words = req_data;

  // While locked, only the owner is visible to the picker; others are masked
  // out even when the owner has nothing to send.
  always_comb begin
    lock_mask        = '0;
    lock_mask[owner] = 1'b1;
    eff_req          = (state == LOCK) ? (req_valid & lock_mask) : req_valid;
  end

  rr_pick4 u_pick (
    .req (eff_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win),
    .any (win_any)
  );

  assign can_accept = !vld || out_ready;
  assign out_xfer   = vld && out_ready;

  // Grant is combinational; suppressed during reset so nothing is accepted
  // before the first post-reset cycle.
  always_comb begin
    req_ready = '0;
    if (rst_n && can_accept && win_any) req_ready = gnt;
  end

  assign in_xfer = |req_ready;

  // Output register and round-robin pointer: load on an input transfer,
  // empty on a drain without refill, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      beat <= '0;
      ptr  <= 2'd3;
    end else if (in_xfer) begin
      vld       <= 1'b1;
      beat.data <= words[win];
      beat.src  <= win;
      ptr       <= win;
    end else if (out_xfer) begin
      vld <= 1'b0;
    end
  end

  // Lock FSM: req_lock only matters on the cycle its owner transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB;
      owner  <= '0;
      locked <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (in_xfer && req_lock[win]) begin
            state  <= LOCK;
            owner  <= win;
            locked <= 1'b1;
          end
        end
        LOCK: begin
          if (in_xfer && !req_lock[win]) begin
            state  <= ARB;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ARB;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld;
  assign out_data  = beat.data;
  assign out_src   = beat.src;

endmodule

// File: tb/tb_arb16_rr4.sv
// Directed bench for arb16_rr4: reset, round-robin order, single requester,
// back-pressure, lock sequence, idle-owner blocking and async reset mid-lock.
module tb_arb16_rr4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        locked;

  int nvec = 0;
  int nerr = 0;

  arb16_rr4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_lock  = 4'b0000;
    req_data  = 64'h0;
    out_ready = 1'b1;
    step();
    step();
    nvec++;
    if (out_valid !== 1'b0 || locked !== 1'b0 || out_src !== 2'd0 || out_data !== 16'h0) begin
      nerr++;
      $display("FAIL reset_state: vld=%b lck=%b src=%0d data=%h, need 0/0/0/0000", out_valid, locked, out_src, out_data);
    end
    nvec++;
    if (req_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_ready: got %b, need 0000", req_ready);
    end
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    #1;
  endtask

  // All four valid: grants rotate 0,1,2,3,0 and out_src trails by a cycle.
  task automatic test_round_robin();
    logic [3:0] ord [5];
    ord = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    req_data  = 64'hD333_D222_D111_D000;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [3:0] eg;
      logic [15:0] ed;
      eg = '0;
      eg[ord[c][1:0]] = 1'b1;
      ed = 16'hD000 | (16'h0111 * 16'(ord[c]));
      #1;
      nvec++;
      if (req_ready !== eg) begin
        nerr++;
        $display("FAIL rr_grant[%0d]: got %b, need %b", c, req_ready, eg);
      end
      step();
      nvec++;
      if (out_valid !== 1'b1 || out_src !== ord[c][1:0] || out_data !== ed) begin
        nerr++;
        $display("FAIL rr_out[%0d]: vld=%b src=%0d data=%h, need 1/%0d/%h", c, out_valid, out_src, out_data, ord[c][1:0], ed);
      end
    end
    req_valid = 4'b0000;
    step();
  endtask

  // Lone requester 2 with 16'h1234; then drain leaves out_valid low.
  task automatic test_single();
    req_data  = 64'h0000_1234_0000_0000;
    req_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL single_grant: got %b, need 0100", req_ready);
    end
    step();
    req_valid = 4'b0000;
    nvec++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_src !== 2'd2) begin
      nerr++;
      $display("FAIL single_out: vld=%b data=%h src=%0d, need 1/1234/2", out_valid, out_data, out_src);
    end
    step();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL drain_empty: out_valid=%b, need 0", out_valid);
    end
  endtask

  // ptr=2 after the single test, so 3 wins; then 3 stalled cycles, then 0.
  task automatic test_back_pressure();
    req_data  = 64'hA333_A222_A111_A000;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 4'b1000) begin
      nerr++;
      $display("FAIL bp_first: got %b, need 1000 (ptr 2)", req_ready);
    end
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_data = 64'hBEEF_BEEF_BEEF_BEEF ^ 64'(c);
      #1;
      nvec++;
      if (req_ready !== 4'b0000) begin
        nerr++;
        $display("FAIL bp_ready[%0d]: got %b, need 0000", c, req_ready);
      end
      step();
      nvec++;
      if (out_valid !== 1'b1 || out_data !== 16'hA333 || out_src !== 2'd3) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: vld=%b data=%h src=%0d, need 1/a333/3", c, out_valid, out_data, out_src);
      end
    end
    req_data  = 64'hA333_A222_A111_A000;
    out_ready = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL bp_release: got %b, need 0001", req_ready);
    end
    step();
    nvec++;
    if (out_src !== 2'd0 || out_data !== 16'hA000) begin
      nerr++;
      $display("FAIL bp_next: src=%0d data=%h, need 0/a000", out_src, out_data);
    end
    req_valid = 4'b0000;
    step();
  endtask

  // ptr=0: requester 1 wins, holds for beats with lock 1,1,0, then 3 wins.
  task automatic test_lock();
    logic [3:0] lk [3];
    logic       el [3];
    lk = '{4'b0010, 4'b0010, 4'b0000};
    el = '{1'b1, 1'b1, 1'b0};
    req_data  = 64'hC333_C222_C111_C000;
    req_valid = 4'b1011;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      req_lock = lk[b];
      #1;
      nvec++;
      if (req_ready !== 4'b0010) begin
        nerr++;
        $display("FAIL lock_grant[%0d]: got %b, need 0010", b, req_ready);
      end
      step();
      nvec++;
      if (locked !== el[b] || out_src !== 2'd1) begin
        nerr++;
        $display("FAIL lock_state[%0d]: locked=%b src=%0d, need %b/1", b, locked, out_src, el[b]);
      end
    end
    req_lock = 4'b0000;
    #1;
    nvec++;
    if (req_ready !== 4'b1000) begin
      nerr++;
      $display("FAIL lock_after: got %b, need 1000", req_ready);
    end
    step();
    req_valid = 4'b0000;
    step();
  endtask

  // Owner idle while locked blocks everyone; async reset mid-lock clears it.
  task automatic test_idle_owner_and_async_reset();
    req_data  = 64'hE333_E222_E111_E000;
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    out_ready = 1'b1;
    step();
    req_valid = 4'b1101;
    req_lock  = 4'b0000;
    #1;
    nvec++;
    if (locked !== 1'b1 || req_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL idle_owner: locked=%b ready=%b, need 1/0000", locked, req_ready);
    end
    step();
    nvec++;
    if (out_valid !== 1'b0 || locked !== 1'b1) begin
      nerr++;
      $display("FAIL idle_drain: vld=%b locked=%b, need 0/1", out_valid, locked);
    end
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    step();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || locked !== 1'b0 || out_data !== 16'h0 || out_src !== 2'd0 || req_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL async_reset: vld=%b lck=%b data=%h src=%0d rdy=%b, need 0/0/0000/0/0000", out_valid, locked, out_data, out_src, req_ready);
    end
    req_lock  = 4'b0000;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL post_reset_grant: got %b, need 0001", req_ready);
    end
    step();
    nvec++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 16'hE000) begin
      nerr++;
      $display("FAIL post_reset_out: vld=%b src=%0d data=%h, need 1/0/e000", out_valid, out_src, out_data);
    end
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_back_pressure();
    test_lock();
    test_idle_owner_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
